// File: rtl/bcd_pkg.sv
// Shared types and constants for the remainder binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/remainder_bcd_conv_if.sv
// Start/result bundle between the remainder stage and the BCD converter.
interface remainder_bcd_conv_if #(
  parameter int N      = 7,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [N-1:0]          bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (output start, bin_in, input busy, done, bcd_out, overflow);
  modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Largest result is 9+3 = 4'hC, so 4-bit arithmetic never wraps.
  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_ADD : digit_i;

endmodule

// File: rtl/remainder_bcd_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   CONV  | one adjust+shift step per clock, cnt_q steps remaining
module remainder_bcd_conv
  import bcd_pkg::*;
#(
  parameter int N      = 7,
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  remainder_bcd_conv_if.slave  bus
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int BW    = 4 * DIGITS;

  conv_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]      bin_q, bin_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              sticky_q, sticky_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [BW-1:0]     adj;
  logic [BW+N-1:0]   shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  // Top bit of the adjusted scratch leaves the register on this shift.
  assign shifted = {adj, bin_q} << 1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    scr_d    = scr_q;
    bcd_d    = bcd_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d    = bus.bin_in;
          scr_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(N);
          state_d  = CONV;
        end
      end
      CONV: begin
        scr_d    = shifted[BW+N-1:N];
        bin_d    = shifted[N-1:0];
        sticky_d = sticky_q | adj[BW-1];
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted[BW+N-1:N];
          ovf_d   = sticky_q | adj[BW-1];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_q    <= '0;
      scr_q    <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      scr_q    <= scr_d;
      bcd_q    <= bcd_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = (state_q == CONV);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
